// File: rtl/instr_fetch.sv
// Instruction fetch unit: reads one instruction word per program counter value,
// holds it for the decoder, then tells the program counter where to go next.
module instr_fetch #(
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_addr,
    output logic [ADDR_W-1:0] next_pc,
    output logic              pc_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [DATA_W-1:0] ir,
    output logic              ir_valid,
    input  logic              ir_ready,
    input  logic              skip,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic              halt,
    output logic              halted,
    output logic              fault
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        HOLD   = 3'd2,
        ADV    = 3'd3,
        HALTED = 3'd4
    } state_t;

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   ir_q, ir_d;
    logic [ADDR_W-1:0]   next_pc_q, next_pc_d;
    logic                fault_q, fault_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            ir_q      <= '0;
            next_pc_q <= '0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ir_q      <= ir_d;
            next_pc_q <= next_pc_d;
            fault_q   <= fault_d;
        end
    end

    // The counter is zeroed in the states that lead into FETCH, so every
    // fetch attempt starts with a fresh timeout budget.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ir_d      = ir_q;
        next_pc_d = next_pc_q;
        fault_d   = fault_q;
        case (state_q)
            IDLE: begin
                state_d = FETCH;
                cnt_d   = '0;
            end
            FETCH: begin
                if (mem_ack) begin
                    ir_d    = mem_rdata;
                    state_d = HOLD;
                end else if (cnt_q == CNT_W'(TIMEOUT)) begin
                    fault_d = 1'b1;
                    state_d = HALTED;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HOLD: begin
                if (ir_ready) begin
                    if (halt) begin
                        state_d = HALTED;
                    end else begin
                        if (jump)
                            next_pc_d = jump_target;
                        else if (skip)
                            next_pc_d = pc_addr + ADDR_W'(2);
                        else
                            next_pc_d = pc_addr + ADDR_W'(1);
                        state_d = ADV;
                    end
                end
            end
            ADV: begin
                state_d = FETCH;
                cnt_d   = '0;
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign mem_rd   = (state_q == FETCH);
    assign mem_addr = pc_addr;
    assign ir_valid = (state_q == HOLD);
    assign pc_en    = (state_q == ADV);
    assign halted   = (state_q == HALTED);
    assign ir       = ir_q;
    assign next_pc  = next_pc_q;
    assign fault    = fault_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: each step drives inputs after a rising edge
// and compares outputs against hand-computed values.
module tb_instr_fetch;

    localparam int ADDR_W  = 5;
    localparam int DATA_W  = 8;
    localparam int TIMEOUT = 15;

    logic              clk;
    logic              rst;
    logic [ADDR_W-1:0] pc_addr;
    logic [ADDR_W-1:0] next_pc;
    logic              pc_en;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;
    logic [DATA_W-1:0] ir;
    logic              ir_valid;
    logic              ir_ready;
    logic              skip;
    logic              jump;
    logic [ADDR_W-1:0] jump_target;
    logic              halt;
    logic              halted;
    logic              fault;

    int checks = 0;
    int errors = 0;

    instr_fetch #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pc_addr    (pc_addr),
        .next_pc    (next_pc),
        .pc_en      (pc_en),
        .mem_addr   (mem_addr),
        .mem_rd     (mem_rd),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .ir         (ir),
        .ir_valid   (ir_valid),
        .ir_ready   (ir_ready),
        .skip       (skip),
        .jump       (jump),
        .jump_target(jump_target),
        .halt       (halt),
        .halted     (halted),
        .fault      (fault)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] simulation did not finish");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic ack, input logic [DATA_W-1:0] rdata,
                                 input logic rdy, input logic sk, input logic jp,
                                 input logic [ADDR_W-1:0] tgt, input logic hl);
        mem_ack     = ack;
        mem_rdata   = rdata;
        ir_ready    = rdy;
        skip        = sk;
        jump        = jp;
        jump_target = tgt;
        halt        = hl;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_ir"}, 32'(ir), 32'h0);
        checkOutput({tag, "_ir_valid"}, 32'(ir_valid), 32'h0);
        checkOutput({tag, "_next_pc"}, 32'(next_pc), 32'h0);
        checkOutput({tag, "_pc_en"}, 32'(pc_en), 32'h0);
        checkOutput({tag, "_mem_rd"}, 32'(mem_rd), 32'h0);
        checkOutput({tag, "_halted"}, 32'(halted), 32'h0);
        checkOutput({tag, "_fault"}, 32'(fault), 32'h0);
    endtask

    initial begin
        rst     = 1'b1;
        pc_addr = 5'd3;
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        #2 rst = 1'b0;
        #2 checkResetOutputs("por");
        tick();
        checkResetOutputs("por_edge");
        #5 rst = 1'b1;

        // Basic fetch at pc 3, ack after two FETCH cycles
        tick();
        checkOutput("fetch_rd", 32'(mem_rd), 32'h1);
        checkOutput("fetch_addr", 32'(mem_addr), 32'd3);
        tick();
        checkOutput("fetch_wait_rd", 32'(mem_rd), 32'h1);
        applyStimulus(1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
        tick();
        checkOutput("cap_ir", 32'(ir), 32'hA5);
        checkOutput("cap_valid", 32'(ir_valid), 32'h1);
        checkOutput("cap_rd", 32'(mem_rd), 32'h0);
        checkOutput("cap_pc_en", 32'(pc_en), 32'h0);
        mem_ack = 1'b0;
        tick();
        checkOutput("adv_pc_en", 32'(pc_en), 32'h1);
        checkOutput("adv_next_pc", 32'(next_pc), 32'd4);
        checkOutput("adv_valid", 32'(ir_valid), 32'h0);
        pc_addr  = 5'd4;
        ir_ready = 1'b0;
        tick();
        checkOutput("refetch_pc_en", 32'(pc_en), 32'h0);
        checkOutput("refetch_rd", 32'(mem_rd), 32'h1);
        checkOutput("refetch_addr", 32'(mem_addr), 32'd4);

        // Decoder stall: five cycles with ir_ready low
        applyStimulus(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        tick();
        mem_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checkOutput("stall_valid", 32'(ir_valid), 32'h1);
            checkOutput("stall_ir", 32'(ir), 32'h3C);
            checkOutput("stall_pc_en", 32'(pc_en), 32'h0);
            checkOutput("stall_rd", 32'(mem_rd), 32'h0);
            checkOutput("stall_next_pc", 32'(next_pc), 32'd4);
            tick();
        end
        ir_ready = 1'b1;
        tick();
        checkOutput("stall_adv_pc_en", 32'(pc_en), 32'h1);
        checkOutput("stall_adv_next_pc", 32'(next_pc), 32'd5);
        ir_ready = 1'b0;
        pc_addr  = 5'd31;
        tick();
        checkOutput("stall_single_pulse", 32'(pc_en), 32'h0);
        checkOutput("pc31_addr", 32'(mem_addr), 32'd31);

        // Wraparound: skip from 31, default from 31, jump beats skip
        applyStimulus(1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        tick();
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0);
        tick();
        checkOutput("skip_wrap", 32'(next_pc), 32'd1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        tick();
        applyStimulus(1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        tick();
        checkOutput("hold_next_pc_stable", 32'(next_pc), 32'd1);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
        tick();
        checkOutput("default_wrap", 32'(next_pc), 32'd0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        tick();
        applyStimulus(1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        tick();
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 5'd9, 1'b0);
        tick();
        checkOutput("jump_prio", 32'(next_pc), 32'd9);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        pc_addr = 5'd9;
        tick();

        // Ack arriving on the 16th FETCH edge is captured without fault
        for (int i = 0; i < 15; i++) begin
            tick();
        end
        checkOutput("late_rd", 32'(mem_rd), 32'h1);
        checkOutput("late_no_fault", 32'(fault), 32'h0);
        applyStimulus(1'b1, 8'h77, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        tick();
        checkOutput("late_valid", 32'(ir_valid), 32'h1);
        checkOutput("late_ir", 32'(ir), 32'h77);
        checkOutput("late_fault", 32'(fault), 32'h0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
        tick();
        checkOutput("late_next_pc", 32'(next_pc), 32'd10);
        ir_ready = 1'b0;
        pc_addr  = 5'd10;
        tick();

        // No ack at all: fault after 16 FETCH edges
        for (int i = 0; i < 15; i++) begin
            tick();
        end
        checkOutput("pre_timeout_halted", 32'(halted), 32'h0);
        checkOutput("pre_timeout_rd", 32'(mem_rd), 32'h1);
        tick();
        checkOutput("timeout_fault", 32'(fault), 32'h1);
        checkOutput("timeout_halted", 32'(halted), 32'h1);
        checkOutput("timeout_rd", 32'(mem_rd), 32'h0);
        applyStimulus(1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
        tick();
        checkOutput("halted_ack_ignored", 32'(ir), 32'h77);
        checkOutput("halted_sticky", 32'(halted), 32'h1);
        checkOutput("halted_no_pc_en", 32'(pc_en), 32'h0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);

        // Reset while halted with fault set
        rst = 1'b0;
        #1 checkResetOutputs("rst_halted");
        #1 rst = 1'b1;
        tick();
        checkOutput("restart_rd", 32'(mem_rd), 32'h1);
        checkOutput("restart_addr", 32'(mem_addr), 32'd10);
        tick();

        // Reset mid-FETCH; an ack during reset must not be captured
        rst = 1'b0;
        #1 checkResetOutputs("rst_fetch");
        applyStimulus(1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        tick();
        checkOutput("rst_ack_ignored", 32'(ir), 32'h0);
        checkOutput("rst_hold_valid", 32'(ir_valid), 32'h0);
        mem_ack = 1'b0;
        rst     = 1'b1;
        tick();
        checkOutput("restart2_rd", 32'(mem_rd), 32'h1);
        checkOutput("restart2_valid", 32'(ir_valid), 32'h0);

        // Halt at accept: no pc_en, fetch stays stopped
        applyStimulus(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        tick();
        checkOutput("halt_ir", 32'(ir), 32'hEE);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1);
        tick();
        checkOutput("halt_halted", 32'(halted), 32'h1);
        checkOutput("halt_fault", 32'(fault), 32'h0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            checkOutput("halt_rd", 32'(mem_rd), 32'h0);
            checkOutput("halt_pc_en", 32'(pc_en), 32'h0);
            checkOutput("halt_next_pc", 32'(next_pc), 32'd0);
            tick();
        end
        checkOutput("halt_final", 32'(halted), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
